// File: rtl/sobel_window_ctrl.sv
// Sobel-Y window sequencer: two line buffers feed a 3-column window whose top
// (row y-2) and bottom (row y) rows drive an external combinational kernel.
// The signed kernel result is turned into a saturated magnitude and emitted
// for interior pixels only, with valid/ready flow control on both sides.
module sobel_window_ctrl #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int BITS_FOR_INDEX = 10,
  parameter int sizeOfWidth    = 8
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [sizeOfWidth-1:0]      in_pix,
  output logic [3*sizeOfWidth-1:0]    row_top,
  output logic [3*sizeOfWidth-1:0]    row_bot,
  input  logic signed [15:0]          kern_res,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [sizeOfWidth-1:0]      out_pix,
  output logic [BITS_FOR_INDEX-1:0]   out_x,
  output logic [BITS_FOR_INDEX-1:0]   out_y,
  output logic                        busy,
  output logic                        done
);
  localparam int BI = BITS_FOR_INDEX;
  localparam int PW = sizeOfWidth;
  localparam logic [BI-1:0] ONE     = BI'(1);
  localparam logic [BI-1:0] TWO     = BI'(2);
  localparam logic [BI-1:0] X_LAST  = BI'(WIDTH - 1);
  localparam logic [BI-1:0] Y_LAST  = BI'(HEIGHT - 1);
  localparam logic [BI-1:0] OX_LAST = BI'(WIDTH - 2);
  localparam logic [BI-1:0] OY_LAST = BI'(HEIGHT - 2);
  localparam logic [15:0]   PIX_MAX = 16'((1 << PW) - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state, state_nxt;
  logic [BI-1:0]       x, y;
  logic [PW-1:0]       lb0 [WIDTH];   // row y-1
  logic [PW-1:0]       lb1 [WIDTH];   // row y-2
  logic [3*PW-1:0]     top_w, bot_w;  // [3PW-1:2PW]=left, [PW-1:0]=right
  logic                s1_valid;
  logic [BI-1:0]       s1_x, s1_y;
  logic                accept, s1_adv, win_ok, last_in, last_out;
  logic [15:0]         mag;
  logic [PW-1:0]       sat;

  assign accept   = in_valid & in_ready;
  assign s1_adv   = s1_valid & (~out_valid | out_ready);
  assign win_ok   = (x >= TWO) && (y >= TWO);
  assign last_in  = accept && (x == X_LAST) && (y == Y_LAST);
  // Outputs leave in raster order, so the bottom-right interior pixel is last.
  assign last_out = out_valid && out_ready && (out_x == OX_LAST) && (out_y == OY_LAST);

  assign in_ready = (state == RUN) && (!s1_valid || s1_adv);
  assign busy     = (state == RUN) || (state == FLUSH);
  assign done     = (state == DONE);
  assign row_top  = top_w;
  assign row_bot  = bot_w;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Frame sequencing: start only matters in IDLE; DONE is a single cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_in)  state_nxt = FLUSH;
      FLUSH:   if (last_out) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Raster position of the next pixel to accept
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      x <= '0;
      y <= '0;
    end else if (state == IDLE && start) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + ONE;
      end else begin
        x <= x + ONE;
      end
    end
  end

  // Line buffers: read old lb0[x] into lb1 while lb0 takes the new pixel
  always_ff @(posedge HCLK) begin
    if (accept) begin
      lb1[x] <= lb0[x];
      lb0[x] <= in_pix;
    end
  end

  // Window shift and stage-1 occupancy (window centred one pixel up-left)
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      top_w    <= '0;
      bot_w    <= '0;
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      if (accept) begin
        top_w <= {top_w[2*PW-1:0], lb1[x]};
        bot_w <= {bot_w[2*PW-1:0], in_pix};
        s1_x  <= x - ONE;
        s1_y  <= y - ONE;
      end
      if (accept && win_ok) s1_valid <= 1'b1;
      else if (s1_adv)      s1_valid <= 1'b0;
    end
  end

  // Magnitude with saturation; -32768 negates to 0x8000 which saturates too
  always_comb begin
    mag = kern_res[15] ? 16'(-kern_res) : 16'(kern_res);
    sat = (mag > PIX_MAX) ? {PW{1'b1}} : mag[PW-1:0];
  end

  // Output register: loads on s1_adv, otherwise holds until taken
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_pix   <= sat;
      out_x     <= s1_x;
      out_y     <= s1_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: a 4x4 instance and an 8x6 instance
// share stimulus; a mux selects whose outputs are observed.
module tb_sobel_window_ctrl;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_pix = '0;
  logic        sel = 1'b0;

  logic        ir_a, ov_a, bz_a, dn_a, ir_b, ov_b, bz_b, dn_b;
  logic [23:0] rt_a, rb_a, rt_b, rb_b;
  logic [15:0] kr_a, kr_b;
  logic [7:0]  op_a, op_b;
  logic [1:0]  ox_a, oy_a;
  logic [2:0]  ox_b, oy_b;

  logic        in_ready, out_valid, busy, done;
  logic [7:0]  out_pix;
  logic [15:0] out_x, out_y;

  int checks = 0;
  int errors = 0;
  int cur_w, cur_h;
  logic [7:0] img [0:7][0:7];
  int lat_acc, lat_ov, first_acc, last_acc;
  bit saw_block;

  always #5 HCLK = ~HCLK;

  // Sobel-Y kernel: bottom row minus top row, centre weighted 2
  function automatic logic [15:0] kern(input logic [23:0] t, input logic [23:0] b);
    int s;
    s = (int'(b[23:16]) + 2 * int'(b[15:8]) + int'(b[7:0]))
      - (int'(t[23:16]) + 2 * int'(t[15:8]) + int'(t[7:0]));
    return 16'(s);
  endfunction

  assign kr_a = kern(rt_a, rb_a);
  assign kr_b = kern(rt_b, rb_b);

  assign in_ready  = sel ? ir_b : ir_a;
  assign out_valid = sel ? ov_b : ov_a;
  assign busy      = sel ? bz_b : bz_a;
  assign done      = sel ? dn_b : dn_a;
  assign out_pix   = sel ? op_b : op_a;
  assign out_x     = sel ? 16'(ox_b) : 16'(ox_a);
  assign out_y     = sel ? 16'(oy_b) : 16'(oy_a);

  sobel_window_ctrl #(.WIDTH(4), .HEIGHT(4), .BITS_FOR_INDEX(2), .sizeOfWidth(8)) u_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start_a), .in_valid(in_valid), .in_ready(ir_a),
    .in_pix(in_pix), .row_top(rt_a), .row_bot(rb_a), .kern_res(kr_a), .out_valid(ov_a),
    .out_ready(out_ready), .out_pix(op_a), .out_x(ox_a), .out_y(oy_a), .busy(bz_a), .done(dn_a));

  sobel_window_ctrl #(.WIDTH(8), .HEIGHT(6), .BITS_FOR_INDEX(3), .sizeOfWidth(8)) u_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start_b), .in_valid(in_valid), .in_ready(ir_b),
    .in_pix(in_pix), .row_top(rt_b), .row_bot(rb_b), .kern_res(kr_b), .out_valid(ov_b),
    .out_ready(out_ready), .out_pix(op_b), .out_x(ox_b), .out_y(oy_b), .busy(bz_b), .done(dn_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_rows(input int v0, input int v1, input int v2, input int v3);
    for (int x = 0; x < 4; x++) begin
      img[0][x] = 8'(v0); img[1][x] = 8'(v1);
      img[2][x] = 8'(v2); img[3][x] = 8'(v3);
    end
  endtask

  // Runs one frame on the selected instance and checks every output
  task automatic run_frame(input string name, input int rdy_pct, input bit mid_start);
    int total, n_exp, idx, oidx, dones, post, cyc, s, m;
    logic [7:0] ep[$];
    int ex[$];
    int ey[$];
    bit stall;
    logic [7:0] s_pix;
    logic [15:0] s_x, s_y;
    total = cur_w * cur_h;
    n_exp = (cur_w - 2) * (cur_h - 2);
    idx = 0; oidx = 0; dones = 0; post = 0; cyc = 0; stall = 1'b0;
    s_pix = '0; s_x = '0; s_y = '0;
    for (int cy = 1; cy < cur_h - 1; cy++)
      for (int cx = 1; cx < cur_w - 1; cx++) begin
        s = (int'(img[cy+1][cx-1]) + 2 * int'(img[cy+1][cx]) + int'(img[cy+1][cx+1]))
          - (int'(img[cy-1][cx-1]) + 2 * int'(img[cy-1][cx]) + int'(img[cy-1][cx+1]));
        m = (s < 0) ? -s : s;
        ep.push_back((m > 255) ? 8'd255 : 8'(m));
        ex.push_back(cx);
        ey.push_back(cy);
      end
    lat_acc = -1; lat_ov = -1; first_acc = -1; last_acc = -1; saw_block = 1'b0;
    @(negedge HCLK);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge HCLK);
    start_a = 1'b0; start_b = 1'b0;
    while (post < 4 && cyc < 2000) begin
      in_valid  = 1'b1;
      in_pix    = (idx < total) ? img[idx / cur_w][idx % cur_w] : 8'hEE;
      out_ready = ($urandom_range(99) < rdy_pct);
      start_a   = mid_start && !sel && (cyc == 5);
      start_b   = mid_start && sel && (cyc == 5);
      #1;
      if (stall) begin
        check($sformatf("%s stall_valid", name), out_valid, 1);
        check($sformatf("%s stall_pix", name), out_pix, s_pix);
        check($sformatf("%s stall_x", name), out_x, s_x);
        check($sformatf("%s stall_y", name), out_y, s_y);
      end
      if (idx < total && busy && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        if (idx == 0) first_acc = cyc;
        if (idx == 2 * cur_w + 2) lat_acc = cyc;
        if (idx == total - 1) last_acc = cyc;
        idx++;
      end
      if (out_valid && lat_ov < 0) lat_ov = cyc;
      if (out_valid && out_ready) begin
        if (oidx < n_exp) begin
          check($sformatf("%s pix#%0d", name, oidx), out_pix, ep[oidx]);
          check($sformatf("%s x#%0d", name, oidx), out_x, ex[oidx]);
          check($sformatf("%s y#%0d", name, oidx), out_y, ey[oidx]);
        end
        oidx++;
      end
      stall = out_valid && !out_ready;
      s_pix = out_pix; s_x = out_x; s_y = out_y;
      if (done) dones++;
      if (dones > 0) begin
        check($sformatf("%s in_ready_after", name), in_ready, 0);
        post++;
      end
      @(negedge HCLK);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; start_a = 1'b0; start_b = 1'b0;
    #1;
    check($sformatf("%s finished_in_budget", name), cyc < 2000, 1);
    check($sformatf("%s out_count", name), oidx, n_exp);
    check($sformatf("%s accepts", name), idx, total);
    check($sformatf("%s done_pulses", name), dones, 1);
    check($sformatf("%s busy_end", name), busy, 0);
  endtask

  initial begin
    int n, cyc;
    // Reset state
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_pix", out_pix, 0);
    check("rst in_ready", in_ready, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst row_top", rt_a, 0);
    check("rst row_bot_b", rb_b, 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    // 1: vertical step 10 -> 50 gives 160 everywhere
    sel = 1'b0; cur_w = 4; cur_h = 4;
    set_rows(10, 10, 50, 50);
    run_frame("s1", 100, 1'b0);

    // 2: saturation and negative results
    set_rows(0, 0, 255, 255);
    run_frame("s2sat", 100, 1'b0);
    set_rows(50, 50, 10, 10);
    run_frame("s2neg", 100, 1'b0);

    // 3: 8x6 random image with random backpressure
    sel = 1'b1; cur_w = 8; cur_h = 6;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 8'($urandom_range(255));
    run_frame("s3", 40, 1'b0);
    check("s3 in_ready_blocked", saw_block, 1);

    // 4: streaming latency and throughput
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 8'($urandom_range(255));
    run_frame("s4", 100, 1'b0);
    check("s4 latency", lat_ov - lat_acc, 2);
    check("s4 throughput", last_acc - first_acc, 8 * 6 - 1);

    // 5: start pulse mid-frame is ignored
    sel = 1'b0; cur_w = 4; cur_h = 4;
    set_rows(10, 10, 50, 50);
    run_frame("s5start", 100, 1'b1);

    // 5: reset after 7 inputs, then a clean frame
    @(negedge HCLK); start_a = 1'b1;
    @(negedge HCLK); start_a = 1'b0;
    n = 0; cyc = 0; in_valid = 1'b1; out_ready = 1'b1;
    while (n < 7 && cyc < 50) begin
      in_pix = 8'd10;
      #1;
      if (in_ready) n++;
      @(negedge HCLK);
      cyc++;
    end
    check("s5 seven_accepts", n, 7);
    HRESETn = 1'b0;
    #1;
    check("s5 rst busy", busy, 0);
    check("s5 rst in_ready", in_ready, 0);
    check("s5 rst out_valid", out_valid, 0);
    check("s5 rst row_bot", rb_a, 0);
    check("s5 rst done", done, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    #1;
    check("s5 idle_no_accept", in_ready, 0);
    check("s5 idle_busy", busy, 0);
    in_valid = 1'b0;
    run_frame("s5after", 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
